// File: rtl/mpsoc_mem_arbiter2.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip memory.
// Round-robin on ties, one transfer issued per cycle, and a
// READ_LATENCY-deep {valid, id} pipeline that routes read data back to
// the issuing master.
module mpsoc_mem_arbiter2 #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_chipselect,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  output logic                  m0_waitrequest,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_chipselect,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic                  m1_waitrequest,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  logic                    w_req0;
  logic                    w_req1;
  logic                    w_gnt0;
  logic                    w_gnt1;
  logic                    w_issue_rd;
  logic                    r_last_grant;   // 1 = master 1 was granted last
  logic [READ_LATENCY-1:0] r_vld;
  logic [READ_LATENCY-1:0] r_id;

  // Request decode, tie-break toward the master not granted last, and stall.
  always_comb begin
    w_req0         = m0_chipselect & (m0_read | m0_write);
    w_req1         = m1_chipselect & (m1_read | m1_write);
    w_gnt0         = w_req0 & (~w_req1 | r_last_grant);
    w_gnt1         = w_req1 & ~w_gnt0;
    m0_waitrequest = w_req0 & ~w_gnt0;
    m1_waitrequest = w_req1 & ~w_gnt1;
    // A strobe with both read and write set is treated as a write only.
    w_issue_rd     = (w_gnt0 & m0_read & ~m0_write) |
                     (w_gnt1 & m1_read & ~m1_write);
  end

  // Memory-side mux: granted master's fields, master 0 fields when idle.
  always_comb begin
    mem_chipselect = w_req0 | w_req1;
    mem_write      = (w_gnt0 & m0_write) | (w_gnt1 & m1_write);
    mem_clken      = 1'b1;
    if (w_gnt1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end else begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
    end
  end

  // Remember the last granted master whenever a transfer is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
    end else if (w_req0 | w_req1) begin
      r_last_grant <= w_gnt1;
    end
  end

  // Read-return pipeline: stage 0 captures the issued read, later stages shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      r_id  <= '0;
    end else begin
      r_vld[0] <= w_issue_rd;
      r_id[0]  <= w_gnt1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end

  // Last stage steers the (unregistered) memory data to its owner.
  always_comb begin
    m0_readdatavalid = r_vld[READ_LATENCY-1] & ~r_id[READ_LATENCY-1];
    m1_readdatavalid = r_vld[READ_LATENCY-1] &  r_id[READ_LATENCY-1];
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
  end

endmodule

// File: doc/mpsoc_mem_arbiter2.md
Name: mpsoc_mem_arbiter2

Overview:
- Two-master Avalon-MM arbiter placed directly upstream of a single-port on-chip memory slave: 14-bit word address, 32-bit data, byteenable, chipselect/write/clken, fixed-latency readdata.
- Lets two Nios II data masters share one memory bank.
- Adds per-master waitrequest and readdatavalid on top of the memory's fixed read latency.
- Issues at most one transaction per cycle, fully pipelined, with round-robin fairness.

Parameters:
- ADDR_W, 14, word address width passed to memory
- DATA_W, 32, data width; byteenable width is DATA_W/8
- READ_LATENCY, 1, cycles from issue to valid mem_readdata; legal values 1 or 2 (2 = memory with registered output)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_address  in  ADDR_W  master 0 word address
- m0_byteenable  in  DATA_W/8  master 0 byte lanes
- m0_chipselect  in  1  master 0 select
- m0_read  in  1  master 0 read strobe
- m0_write  in  1  master 0 write strobe
- m0_writedata  in  DATA_W  master 0 write data
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data valid
- m0_waitrequest  out  1  master 0 stall
- m1_*  same set as m0_*  master 1
- mem_address  out  ADDR_W  to memory address
- mem_byteenable  out  DATA_W/8  to memory byteenable
- mem_chipselect  out  1  to memory chipselect
- mem_write  out  1  to memory write
- mem_writedata  out  DATA_W  to memory writedata
- mem_clken  out  1  to memory clken; constant 1
- mem_readdata  in  DATA_W  from memory readdata

Behaviour:
- Request decode: reqX = mX_chipselect & (mX_read | mX_write). If read and write are both high, the transfer is a write and no read response is produced.
- Arbitration (combinational, same cycle):
  - Only one request: it is granted.
  - Both requesting: grant the master not recorded in last_grant.
  - last_grant updates on every issued transfer to the granted master; reset value 1, so m0 wins the first tie.
- Stall: mX_waitrequest = reqX & ~gntX. It is 0 when the master is not requesting. A stalled master must hold its signals; worst-case stall under contention is 1 cycle.
- Issue:
  - mem_chipselect = req0 | req1.
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted master (master 0 fields when idle).
  - mem_write = granted master's write.
  - Back-to-back issue allowed every cycle, no bubbles.
- Read return:
  - Shift pipeline of READ_LATENCY stages holding {valid, master_id}. A stage is loaded with valid=1 on an issued read.
  - At the last stage: mX_readdatavalid = valid & (id==X).
  - m0_readdata = m1_readdata = mem_readdata, unregistered; only meaningful when the corresponding valid is high.
  - Responses return in issue order; at most one readdatavalid per cycle across both masters.
- Writes: complete in the issue cycle; no response.
- Reset (async assert, sync deassert external):
  - Pipeline valid bits cleared, last_grant=1.
  - All readdatavalid = 0.
  - waitrequest follows its equation (0 with no requests).
  - A read in flight at reset is dropped; no readdatavalid after release.
- mem_clken tied 1; no stall of the memory itself.

Test Plan:
- Single read: m0 read addr 0x0010 (memory preloaded 0xDEADBEEF) → m0_waitrequest=0, mem_address=0x0010. READ_LATENCY=1: m0_readdatavalid=1 with m0_readdata=0xDEADBEEF the next cycle; m1_readdatavalid stays 0.
- Simultaneous reads after reset: m0 addr 0x0001, m1 addr 0x0002 held high → cycle0 grants m0 (m1_waitrequest=1), cycle1 grants m1. readdatavalid pulses m0 then m1 in consecutive cycles with the correct data.
- Sustained contention, 8 cycles, both masters issuing reads continuously → grants strictly alternate m0,m1,m0,…; each master gets exactly 4 readdatavalid pulses; no master stalled more than 1 consecutive cycle.
- Byte write then read: m1 writes 0x000000AB, byteenable 0001, to address 0x3FFF over prior 0x11223344; m1 reads back → readdata=0x112233AB. Top address shows no wrap or aliasing.
- Read and write both asserted: m0 read=write=1, data 0x5A5A5A5A, addr 0x0100 → memory written; no m0_readdatavalid ever.
- Reset mid-read: m0 issues a read, reset_n pulled low in the following cycle before valid → readdatavalid stays 0. After release, the first tie grants m0.
- READ_LATENCY=2 variant: back-to-back m0 read, m1 read, m0 read → three readdatavalid pulses, 2 cycles after each issue, in order.
